// File: rtl/double_multiplier.sv
// rtl/double_multiplier.sv - four-operand IEEE-754 single product R = (A*B)*(C*D)
// One shared single-cycle fp multiplier is time-shared across MUL1..MUL3.
module double_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD2 = 3'd1,
        MUL1  = 3'd2,
        MUL2  = 3'd3,
        MUL3  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, c_q, d_q;
    logic [31:0] p1_q, p2_q;
    logic [31:0] res_q;
    logic        done_q;
    logic [31:0] mul_x, mul_y, mul_r;

    // Flush-to-zero multiply with RNE rounding; no subnormal inputs or outputs.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               sign;
        logic [7:0]         ex, ey;
        logic [22:0]        fx, fy;
        logic               x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        logic [47:0]        prod;
        logic [22:0]        frac;
        logic               g, r, s;
        logic [24:0]        sig_r;
        logic signed [9:0]  exp;
        logic [31:0]        out;

        sign   = x[31] ^ y[31];
        ex     = x[30:23];
        ey     = y[30:23];
        fx     = x[22:0];
        fy     = y[22:0];
        x_nan  = (ex == 8'hFF) && (fx != 23'd0);
        y_nan  = (ey == 8'hFF) && (fy != 23'd0);
        x_inf  = (ex == 8'hFF) && (fx == 23'd0);
        y_inf  = (ey == 8'hFF) && (fy == 23'd0);
        x_zero = (ex == 8'h00);
        y_zero = (ey == 8'h00);

        prod = {24'd0, 1'b1, fx} * {24'd0, 1'b1, fy};
        exp  = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127;

        if (prod[47]) begin
            exp  = exp + 10'sd1;
            frac = prod[46:24];
            g    = prod[23];
            r    = prod[22];
            s    = |prod[21:0];
        end else begin
            frac = prod[45:23];
            g    = prod[22];
            r    = prod[21];
            s    = |prod[20:0];
        end

        sig_r = {2'b01, frac} + {24'd0, g & (r | s | frac[0])};
        // A carry out of rounding leaves an all-zero fraction one binade up.
        if (sig_r[24]) begin
            exp  = exp + 10'sd1;
            frac = sig_r[23:1];
        end else begin
            frac = sig_r[22:0];
        end

        if (x_nan || y_nan) begin
            out = QNAN;
        end else if (x_inf || y_inf) begin
            out = (x_zero || y_zero) ? QNAN : {sign, 8'hFF, 23'd0};
        end else if (x_zero || y_zero) begin
            out = {sign, 31'd0};
        end else if (exp >= 10'sd255) begin
            out = {sign, 8'hFF, 23'd0};
        end else if (exp <= 10'sd0) begin
            out = {sign, 31'd0};
        end else begin
            out = {sign, exp[7:0], frac};
        end
        return out;
    endfunction

    always_comb begin
        mul_x = a_q;
        mul_y = b_q;
        case (state_q)
            MUL2: begin
                mul_x = c_q;
                mul_y = d_q;
            end
            MUL3: begin
                mul_x = p1_q;
                mul_y = p2_q;
            end
            default: ;
        endcase
        mul_r = fp_mul(mul_x, mul_y);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ready) state_d = LOAD2;
            LOAD2:   state_d = MUL1;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = MUL3;
            MUL3:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // done is registered from the DONE state, so it is seen the cycle after E5.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            c_q    <= 32'd0;
            d_q    <= 32'd0;
            p1_q   <= 32'd0;
            p2_q   <= 32'd0;
            res_q  <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == IDLE && ready) begin
                a_q <= op1;
                b_q <= op2;
            end
            if (state_q == LOAD2) begin
                c_q <= op1;
                d_q <= op2;
            end
            if (state_q == MUL1) p1_q  <= mul_r;
            if (state_q == MUL2) p2_q  <= mul_r;
            if (state_q == MUL3) res_q <= mul_r;
        end
    end

    assign res  = res_q;
    assign done = done_q;

endmodule

// File: tb/tb_double_multiplier.sv
// tb/tb_double_multiplier.sv - randomized check of double_multiplier against an arithmetic model
module tb_double_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] op1, op2;
    logic [31:0] res;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    double_multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .op1   (op1),
        .op2   (op2),
        .res   (res),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Exact integer product, then round by comparing the discarded remainder to half an ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int              ex, ey, e, sh;
        logic            s;
        bit              xn, yn, xi, yi, xz, yz;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn) return 32'h7FC00000;
        if (xi || yi) return (xz || yz) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
        if (xz || yz) return {s, 31'h0};
        p    = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        e    = ex + ey - 127 + (sh - 23);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 7))
                    0: return 32'h00000000;
                    1: return 32'h80000000;
                    2: return 32'h7F800000;
                    3: return 32'hFF800000;
                    4: return 32'h7FC00000;
                    5: return 32'hFF800001;
                    6: return 32'h00000123;
                    default: return 32'h807FFFFF;
                endcase
            end
            1: return $urandom;
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
    endfunction

    // Drives one operation; returns res sampled after E5 and the cycle at which done first rose.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] d, input bit noise, input bit b2b,
                          output logic [31:0] r, output int lat);
        if (!b2b) begin
            @(negedge clk);
            chk("done_width", {31'd0, done}, 32'd0);
        end
        ready = 1'b1;
        op1   = a;
        op2   = b;
        @(negedge clk);
        ready = 1'b0;
        op1   = c;
        op2   = d;
        lat   = -1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (done && lat < 0) lat = i;
            op1   = $urandom;
            op2   = $urandom;
            ready = (noise && i <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        r = res;
    endtask

    logic [31:0] dir_tab [9][5];
    logic [31:0] r, ea, eb, ec, ed, exp_r;
    int          lat, done_cnt;

    initial begin
        dir_tab[0] = '{32'h40000000, 32'h40200000, 32'h3FA00000, 32'h3F800000, 32'h40C80000};
        dir_tab[1] = '{32'h42C86666, 32'h80000000, 32'hFF800000, 32'h45185B75, 32'h7FC00000};
        dir_tab[2] = '{32'hC0000000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'hC0C00000};
        dir_tab[3] = '{32'h7F000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h7F800000};
        dir_tab[4] = '{32'h0D800000, 32'h0D800000, 32'h3F800000, 32'h3F800000, 32'h00000000};
        dir_tab[5] = '{32'h3F800001, 32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h3F800002};
        dir_tab[6] = '{32'h3F800001, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h3FC00002};
        dir_tab[7] = '{32'h3F800003, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h3FC00004};
        dir_tab[8] = '{32'h40000000, 32'h40200000, 32'h3FA00000, 32'h3F800000, 32'h40C80000};

        rst   = 1'b1;
        ready = 1'b0;
        op1   = 32'd0;
        op2   = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_res", res, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);

        // Directed cases; entry 2 carries ready noise, entry 8 is accepted right after DONE.
        for (int k = 0; k < 9; k++) begin
            run_op(dir_tab[k][0], dir_tab[k][1], dir_tab[k][2], dir_tab[k][3],
                   (k == 2), (k == 8), r, lat);
            chk($sformatf("dir%0d_lat", k), 32'(lat), 32'd5);
            chk($sformatf("dir%0d_res", k), r, dir_tab[k][4]);
        end

        // Reset during MUL2 must abort without a done pulse and clear res.
        @(negedge clk);
        ready = 1'b1;
        op1   = 32'h40000000;
        op2   = 32'h40400000;
        @(negedge clk);
        ready = 1'b0;
        op1   = 32'h40000000;
        op2   = 32'h40000000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("rst_abort_done", 32'(done_cnt), 32'd0);
        chk("rst_abort_res", res, 32'd0);

        for (int n = 0; n < 300; n++) begin
            ea    = rand_op();
            eb    = rand_op();
            ec    = rand_op();
            ed    = rand_op();
            exp_r = ref_mul(ref_mul(ea, eb), ref_mul(ec, ed));
            run_op(ea, eb, ec, ed, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), r, lat);
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd5);
            chk($sformatf("rnd%0d_res", n), r, exp_r);
        end

        @(negedge clk);
        chk("final_done_low", {31'd0, done}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
